// File: rtl/alu_pkg.sv
// Opcode map, flag bundle and opcode-class helper shared by the pipelined ALU.
package alu_pkg;

    localparam logic [4:0] ADD  = 5'b00000;
    localparam logic [4:0] ADDU = 5'b00001;
    localparam logic [4:0] SUB  = 5'b00010;
    localparam logic [4:0] SUBU = 5'b00011;
    localparam logic [4:0] INC  = 5'b00100;
    localparam logic [4:0] DEC  = 5'b00101;
    localparam logic [4:0] AND  = 5'b01000;
    localparam logic [4:0] OR   = 5'b01001;
    localparam logic [4:0] XOR  = 5'b01010;
    localparam logic [4:0] NOT  = 5'b01100;
    localparam logic [4:0] SLL  = 5'b10000;
    localparam logic [4:0] SRL  = 5'b10001;
    localparam logic [4:0] SLA  = 5'b10010;
    localparam logic [4:0] SRA  = 5'b10011;
    localparam logic [4:0] SLE  = 5'b11000;
    localparam logic [4:0] SLT  = 5'b11001;
    localparam logic [4:0] SGE  = 5'b11010;
    localparam logic [4:0] SGT  = 5'b11011;
    localparam logic [4:0] SEQ  = 5'b11100;
    localparam logic [4:0] SNE  = 5'b11101;

    typedef struct packed {
        logic vout;
        logic cout;
        logic illegal;
    } alu_flags_t;

    // add, addu, sub, subu, inc, dec all sit in 00000..00101
    function automatic logic is_arith(input logic [4:0] op);
        return (op[4:3] == 2'b00) && (op[2:0] <= 3'd5);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder for add/addu/sub/subu/inc/dec, selected by the low three opcode bits.
module alu_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] sum,
    output logic             vout,
    output logic             cout
);

    logic             subtract;
    logic             signed_op;
    logic [WIDTH-1:0] rhs;
    logic [WIDTH-1:0] rhs_x;
    logic [WIDTH:0]   total;

    always_comb begin
        subtract  = 1'b0;
        signed_op = 1'b0;
        case (op)
            3'b000: signed_op = 1'b1;
            3'b010: begin subtract = 1'b1; signed_op = 1'b1; end
            3'b011: subtract = 1'b1;
            3'b100: signed_op = 1'b1;
            3'b101: begin subtract = 1'b1; signed_op = 1'b1; end
            default: ;
        endcase

        // inc/dec reuse the adder with a constant 1 as the second operand
        rhs   = op[2] ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
        rhs_x = subtract ? ~rhs : rhs;
        total = {1'b0, a} + {1'b0, rhs_x} + {{WIDTH{1'b0}}, subtract};
        sum   = total[WIDTH-1:0];
        cout  = total[WIDTH];
        vout  = signed_op & (a[WIDTH-1] == rhs_x[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU: stage 1 registers operands, stage 2 computes and registers results.
// Define ALU_SAT_EN to saturate signed add/sub/inc/dec results on overflow.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       alu_code,
    input  logic             coe,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             vout,
    output logic             cout,
    output logic             illegal,
    output logic             vout_sticky,
    input  logic             clr_sticky
);

    localparam int SHW = $clog2(WIDTH);
`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [4:0]       s1_code_q, s1_code_d;
    logic             s1_coe_q, s1_coe_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] c_q, c_d;
    alu_flags_t       flags_q, flags_d;
    logic             sticky_q, sticky_d;

    logic             s2_load;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] as_sum;
    logic             as_vout;
    logic             as_cout;
    logic [WIDTH-1:0] res_c;
    alu_flags_t       res_flg;

    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = rst_n && (!s1_valid_q || s2_load);
    assign amt      = s1_b_q[SHW-1:0];

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a    (s1_a_q),
        .b    (s1_b_q),
        .op   (s1_code_q[2:0]),
        .sum  (as_sum),
        .vout (as_vout),
        .cout (as_cout)
    );

    always_comb begin
        res_c   = '0;
        res_flg = '0;
        if (is_arith(s1_code_q)) begin
            res_c        = as_sum;
            res_flg.vout = as_vout;
            res_flg.cout = as_cout & ~s1_coe_q;
`ifdef ALU_SAT_EN
            // overflow direction follows the sign of a for add, sub, inc and dec alike
            if (as_vout)
                res_c = s1_a_q[WIDTH-1] ? SMIN : SMAX;
`endif
        end else begin
            case (s1_code_q)
                AND: res_c = s1_a_q & s1_b_q;
                OR:  res_c = s1_a_q | s1_b_q;
                XOR: res_c = s1_a_q ^ s1_b_q;
                NOT: res_c = ~s1_a_q;
                SLL: res_c = s1_a_q << amt;
                SRL: res_c = s1_a_q >> amt;
                SRA: res_c = $signed(s1_a_q) >>> amt;
                SLA: res_c = {s1_a_q[WIDTH-1], (WIDTH-1)'(s1_a_q << amt)};
                SLE: res_c = {{(WIDTH-1){1'b0}}, $signed(s1_a_q) <= $signed(s1_b_q)};
                SLT: res_c = {{(WIDTH-1){1'b0}}, $signed(s1_a_q) <  $signed(s1_b_q)};
                SGE: res_c = {{(WIDTH-1){1'b0}}, $signed(s1_a_q) >= $signed(s1_b_q)};
                SGT: res_c = {{(WIDTH-1){1'b0}}, $signed(s1_a_q) >  $signed(s1_b_q)};
                SEQ: res_c = {{(WIDTH-1){1'b0}}, s1_a_q == s1_b_q};
                SNE: res_c = {{(WIDTH-1){1'b0}}, s1_a_q != s1_b_q};
                default: res_flg.illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_code_d   = s1_code_q;
        s1_coe_d    = s1_coe_q;
        out_valid_d = out_valid_q;
        c_d         = c_q;
        flags_d     = flags_q;
        sticky_d    = sticky_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d    = a;
                s1_b_d    = b;
                s1_code_d = alu_code;
                s1_coe_d  = coe;
            end
        end

        // result registers only change when they are empty or being drained
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                c_d     = res_c;
                flags_d = res_flg;
            end
        end

        if (out_valid_q && out_ready && flags_q.vout)
            sticky_d = 1'b1;
        else if (clr_sticky)
            sticky_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_code_q   <= '0;
            s1_coe_q    <= 1'b0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            flags_q     <= '0;
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_code_q   <= s1_code_d;
            s1_coe_q    <= s1_coe_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            flags_q     <= flags_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign c           = c_q;
    assign vout        = flags_q.vout;
    assign cout        = flags_q.cout;
    assign illegal     = flags_q.illegal;
    assign vout_sticky = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=16): directed vector table, stall/sticky/reset sequences, random stream vs model.
module tb_alu_pipe;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [4:0]    alu_code;
    logic          coe;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  c;
    logic          vout;
    logic          cout;
    logic          illegal;
    logic          vout_sticky;
    logic          clr_sticky;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_code    (alu_code),
        .coe         (coe),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .c           (c),
        .vout        (vout),
        .cout        (cout),
        .illegal     (illegal),
        .vout_sticky (vout_sticky),
        .clr_sticky  (clr_sticky)
    );

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        coe;
        logic [15:0] c;
        logic        v;
        logic        co;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [15:0] c;
        logic        v;
        logic        co;
        logic        ill;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   retired = 0;
    res_t exp_q[$];
    logic sticky_m = 1'b0;
    bit   last_acc;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic res_t model(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y,
                                   input logic coe_n);
        res_t r;
        int sx, sy, ux, uy, s, p;
        r.c = 16'h0; r.v = 1'b0; r.co = 1'b0; r.ill = 1'b0;
        sx = $signed(x); sy = $signed(y);
        ux = x; uy = y;
        p  = 1 << (uy % 16);
        s  = 0;
        case (op)
            5'd0, 5'd1: begin s = sx + sy; r.c = 16'(ux + uy); r.co = (ux + uy) > 65535; end
            5'd2, 5'd3: begin s = sx - sy; r.c = 16'(ux - uy); r.co = (ux >= uy); end
            5'd4:       begin s = sx + 1;  r.c = 16'(ux + 1);  r.co = (ux == 65535); end
            5'd5:       begin s = sx - 1;  r.c = 16'(ux - 1);  r.co = (ux >= 1); end
            5'd8:  r.c = x & y;
            5'd9:  r.c = x | y;
            5'd10: r.c = x ^ y;
            5'd12: r.c = 16'(65535 - ux);
            5'd16: r.c = 16'((ux * p) % 65536);
            5'd17: r.c = 16'(ux / p);
            5'd18: r.c = 16'((ux / 32768) * 32768 + (ux * p) % 32768);
            5'd19: r.c = 16'((sx >= 0) ? (sx / p) : -((-sx + p - 1) / p));
            5'd24: r.c = (sx <= sy) ? 16'd1 : 16'd0;
            5'd25: r.c = (sx <  sy) ? 16'd1 : 16'd0;
            5'd26: r.c = (sx >= sy) ? 16'd1 : 16'd0;
            5'd27: r.c = (sx >  sy) ? 16'd1 : 16'd0;
            5'd28: r.c = (ux == uy) ? 16'd1 : 16'd0;
            5'd29: r.c = (ux != uy) ? 16'd1 : 16'd0;
            default: r.ill = 1'b1;
        endcase
        if (op == 5'd0 || op == 5'd2 || op == 5'd4 || op == 5'd5)
            r.v = (s > 32767) || (s < -32768);
`ifdef ALU_SAT_EN
        if (r.v)
            r.c = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
        if (coe_n)
            r.co = 1'b0;
        return r;
    endfunction

    function automatic vec_t mk(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y,
                                input logic ce, input logic [15:0] rc, input logic rv,
                                input logic rco, input logic ril);
        vec_t v;
        v.op = op; v.a = x; v.b = y; v.coe = ce; v.c = rc; v.v = rv; v.co = rco; v.ill = ril;
        return v;
    endfunction

    // One clock: observe handshakes just before the edge, update scoreboard, return at posedge+1
    task automatic tick();
        res_t e;
        @(negedge clk);
        last_acc = (in_valid && in_ready);
        if (last_acc)
            exp_q.push_back(model(alu_code, a, b, coe));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_retire", 32'd1, 32'd0);
                e.c = 16'h0; e.v = 1'b0; e.co = 1'b0; e.ill = 1'b0;
            end else begin
                e = exp_q.pop_front();
                chk("retire_result", {c, vout, cout, illegal}, {e.c, e.v, e.co, e.ill});
            end
            $display("retire #%0d c=%h vout=%b cout=%b illegal=%b", retired, c, vout, cout, illegal);
            retired++;
            if (e.v) sticky_m = 1'b1;
            else if (clr_sticky) sticky_m = 1'b0;
        end else if (clr_sticky) begin
            sticky_m = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit got = 0;
        int lat = -1;
        in_valid = 1'b1; alu_code = v.op; a = v.a; b = v.b; coe = v.coe; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            if (out_valid) begin
                got = 1;
                lat = n;
                chk($sformatf("vec%0d", idx), {c, vout, cout, illegal}, {v.c, v.v, v.co, v.ill});
                $display("vec %0d op=%b a=%h b=%h -> c=%h v=%b co=%b ill=%b",
                         idx, v.op, v.a, v.b, c, vout, cout, illegal);
            end
            tick();
        end
        chk($sformatf("vec%0d_latency", idx), lat, 1);
        chk($sformatf("vec%0d_sticky", idx), {31'd0, vout_sticky}, {31'd0, sticky_m});
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 12 && exp_q.size() > 0; n++)
            tick();
        chk(name, exp_q.size(), 0);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [15:0] sat_add, sat_sub;
        logic [15:0] prev_c;
        bit          stalled_prev;
        bit          saw_full;
        int          sent;

`ifdef ALU_SAT_EN
        sat_add = 16'h7FFF; sat_sub = 16'h8000;
`else
        sat_add = 16'h8000; sat_sub = 16'h7FFF;
`endif
        vecs.push_back(mk(5'b00000, 16'h7FFF, 16'h0001, 1'b0, sat_add,  1, 0, 0)); // add overflow
        vecs.push_back(mk(5'b00011, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 0, 0, 0)); // subu borrow
        vecs.push_back(mk(5'b00011, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 0, 0, 0));
        vecs.push_back(mk(5'b00001, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 0, 1, 0)); // addu carry
        vecs.push_back(mk(5'b00001, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 0, 0, 0)); // coe=1 kills carry
        vecs.push_back(mk(5'b00010, 16'h8000, 16'h0001, 1'b0, sat_sub,  1, 1, 0)); // sub overflow
        vecs.push_back(mk(5'b00010, 16'h0005, 16'h0003, 1'b0, 16'h0002, 0, 1, 0));
        vecs.push_back(mk(5'b00100, 16'h7FFF, 16'h0000, 1'b0, sat_add,  1, 0, 0)); // inc overflow
        vecs.push_back(mk(5'b00101, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 0, 0, 0)); // dec borrow
        vecs.push_back(mk(5'b00000, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(5'b10011, 16'h8000, 16'h000F, 1'b0, 16'hFFFF, 0, 0, 0)); // sra
        vecs.push_back(mk(5'b10010, 16'hC001, 16'h0003, 1'b0, 16'h8008, 0, 0, 0)); // sla
        vecs.push_back(mk(5'b10001, 16'h8000, 16'h000F, 1'b0, 16'h0001, 0, 0, 0)); // srl
        vecs.push_back(mk(5'b10000, 16'h0001, 16'h000F, 1'b0, 16'h8000, 0, 0, 0)); // sll max
        vecs.push_back(mk(5'b10000, 16'hA5A5, 16'h0010, 1'b0, 16'hA5A5, 0, 0, 0)); // amt=0
        vecs.push_back(mk(5'b01000, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 0, 0, 0));
        vecs.push_back(mk(5'b01001, 16'hF0F0, 16'hFF00, 1'b0, 16'hFFF0, 0, 0, 0));
        vecs.push_back(mk(5'b01010, 16'hF0F0, 16'hFF00, 1'b0, 16'h0FF0, 0, 0, 0));
        vecs.push_back(mk(5'b01100, 16'hF0F0, 16'hFF00, 1'b0, 16'h0F0F, 0, 0, 0));
        vecs.push_back(mk(5'b11001, 16'hFFFF, 16'h0001, 1'b0, 16'h0001, 0, 0, 0)); // slt signed
        vecs.push_back(mk(5'b11000, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 0, 0, 0));
        vecs.push_back(mk(5'b11010, 16'h0001, 16'hFFFF, 1'b0, 16'h0001, 0, 0, 0));
        vecs.push_back(mk(5'b11011, 16'h8000, 16'h7FFF, 1'b0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(5'b11100, 16'h1234, 16'h1234, 1'b0, 16'h0001, 0, 0, 0));
        vecs.push_back(mk(5'b11101, 16'h1234, 16'h1234, 1'b0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(5'b00110, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 0, 0, 1)); // unmapped

        // Reset held three cycles with in_valid asserted
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; clr_sticky = 1'b0;
        alu_code = 5'b00000; a = 16'h0003; b = 16'h0004; coe = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        end
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_outputs", {c, vout, cout, illegal, vout_sticky}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("first_accept", {31'd0, last_acc}, 32'd1);
        drain("reset_drain");

        foreach (vecs[i])
            run_vec(vecs[i], i);

        // Back-pressure: six back-to-back beats, downstream stalls cycles 3..5
        sent = 0; stalled_prev = 0; saw_full = 0; prev_c = '0;
        for (int cy = 0; cy < 24 && (sent < 6 || exp_q.size() > 0); cy++) begin
            out_ready = !(cy >= 3 && cy <= 5);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                alu_code = (sent % 2 == 0) ? 5'b00000 : 5'b10000;
                a = 16'h1111 * 16'(sent + 1);
                b = 16'(sent + 1);
                coe = 1'b0;
            end
            #1;
            if (stalled_prev && out_valid)
                chk("stall_hold_c", {16'd0, c}, {16'd0, prev_c});
            if (in_valid && !in_ready)
                saw_full = 1;
            stalled_prev = out_valid && !out_ready;
            prev_c = c;
            tick();
            if (last_acc) sent++;
        end
        chk("bp_in_ready_dropped", {31'd0, saw_full}, 32'd1);
        chk("bp_all_sent", sent, 6);
        chk("bp_all_retired", exp_q.size(), 0);

        // Sticky: clear alone, then clear coinciding with a vout=1 retire
        in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("sticky_cleared", {31'd0, vout_sticky}, 32'd0);
        in_valid = 1'b1; alu_code = 5'b00000; a = 16'h7FFF; b = 16'h0001; coe = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 8 && !out_valid; n++)
            tick();
        chk("sticky_wait_valid", {31'd0, out_valid}, 32'd1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("sticky_set_wins", {31'd0, vout_sticky}, 32'd1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("sticky_clear_after", {31'd0, vout_sticky}, 32'd0);

        // Random stream with random back-pressure and clears
        for (int cy = 0; cy < 400; cy++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 7);
            clr_sticky = ($urandom_range(0, 9) == 0);
            alu_code   = 5'($urandom_range(0, 31));
            a          = pick();
            b          = pick();
            coe        = 1'($urandom_range(0, 1));
            tick();
            chk("rand_sticky", {31'd0, vout_sticky}, {31'd0, sticky_m});
        end
        clr_sticky = 1'b0;
        drain("rand_drain");

        // Reset mid-flight discards both stages
        in_valid = 1'b1; out_ready = 1'b0; alu_code = 5'b00000; a = 16'h7FFF; b = 16'h0001;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        exp_q.delete();
        sticky_m = 1'b0;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_sticky", {31'd0, vout_sticky}, 32'd0);
        begin
            bit leaked = 0;
            for (int n = 0; n < 4; n++) begin
                if (out_valid) leaked = 1;
                tick();
            end
            chk("midreset_nothing_emerges", {31'd0, leaked}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
